// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, types and reset value for the write-back register bank
package regfile_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int NUM_REGS = 8;
  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;
  localparam reg_data_t RESET_VALUE = 16'h0000;
endpackage

// File: rtl/regfile_wr_decoder.sv
// regfile_wr_decoder: address plus enable to one-hot register strobes
// Ports: addr - register index, en - strobe enable, stb - one-hot strobes (all zero when en=0)
module regfile_wr_decoder
  import regfile_pkg::*;
(
  input  reg_addr_t             addr,
  input  logic                  en,
  output logic [NUM_REGS-1:0]   stb
);
  always_comb stb = en ? (NUM_REGS'(1) << addr) : '0;
endmodule

// File: rtl/regfile_writeback_8x16.sv
// regfile_writeback_8x16: eight 16-bit registers with a one-entry write-back slot and forwarding read ports
// Ports: clk/rst_n - clock and async active-low reset; wr_valid/wr_ready/wr_addr/wr_data - write handshake;
//        hold - stalls commit of the pending slot; rd_{a,b}_addr/rd_{a,b}_data - combinational read ports;
//        pend_mask - one-hot of the uncommitted register; commit_cnt - wrapping count of commits
module regfile_writeback_8x16
  import regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  reg_addr_t             wr_addr,
  input  reg_data_t             wr_data,
  input  logic                  hold,
  input  reg_addr_t             rd_a_addr,
  output reg_data_t             rd_a_data,
  input  reg_addr_t             rd_b_addr,
  output reg_data_t             rd_b_data,
  output logic [NUM_REGS-1:0]   pend_mask,
  output logic [15:0]           commit_cnt
);
  reg_data_t regs [NUM_REGS];
  logic pend_valid;
  reg_addr_t pend_addr;
  reg_data_t pend_data;
  logic commit, accept;
  logic [NUM_REGS-1:0] wr_stb;
  assign commit = pend_valid & ~hold;
  // a full slot can still accept when it commits in the same cycle
  assign wr_ready = ~pend_valid | ~hold;
  assign accept = wr_valid & wr_ready;
  regfile_wr_decoder u_wr_dec (.addr(pend_addr), .en(commit), .stb(wr_stb));
  regfile_wr_decoder u_mask_dec (.addr(pend_addr), .en(pend_valid), .stb(pend_mask));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_addr <= '0;
      pend_data <= RESET_VALUE;
      commit_cnt <= '0;
      regs <= '{default: RESET_VALUE};
    end else begin
      for (int k = 0; k < NUM_REGS; k++)
        if (wr_stb[k]) regs[k] <= pend_data;
      if (accept) begin
        pend_addr <= wr_addr;
        pend_data <= wr_data;
      end
      pend_valid <= accept | (pend_valid & ~commit);
      if (commit) commit_cnt <= commit_cnt + 16'd1;
    end
  end
  // the pending slot holds the newest accepted value, so it shadows the register
  assign rd_a_data = (pend_valid && rd_a_addr == pend_addr) ? pend_data : regs[rd_a_addr];
  assign rd_b_data = (pend_valid && rd_b_addr == pend_addr) ? pend_data : regs[rd_b_addr];
endmodule

// File: tb/tb_regfile_writeback_8x16.sv
// tb_regfile_writeback_8x16: vector table, directed corner sequences and randomized model comparison
module tb_regfile_writeback_8x16;
  logic clk = 1'b0, rst_n = 1'b0, wr_valid = 1'b0, hold = 1'b0, wr_ready;
  logic [2:0] wr_addr = '0, rd_a_addr = '0, rd_b_addr = '0;
  logic [15:0] wr_data = '0, rd_a_data, rd_b_data, commit_cnt;
  logic [7:0] pend_mask;
  int n_vec = 0, n_bad = 0;
  always #5 clk = ~clk;
  regfile_writeback_8x16 dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .hold(hold),
    .rd_a_addr(rd_a_addr), .rd_a_data(rd_a_data),
    .rd_b_addr(rd_b_addr), .rd_b_data(rd_b_data),
    .pend_mask(pend_mask), .commit_cnt(commit_cnt)
  );
  typedef struct { logic [2:0] a; logic [15:0] d; } wr_t;
  logic [15:0] m_regs [8];
  wr_t m_q [$];
  int unsigned m_cnt;
  task automatic model_reset();
    foreach (m_regs[i]) m_regs[i] = 16'h0000;
    m_q.delete();
    m_cnt = 0;
  endtask
  function automatic logic m_ready();
    return m_q.size() == 0 || !hold;
  endfunction
  function automatic logic [15:0] m_read(logic [2:0] a);
    if (m_q.size() != 0 && m_q[0].a == a) return m_q[0].d;
    return m_regs[a];
  endfunction
  function automatic logic [7:0] m_mask();
    logic [7:0] m = '0;
    if (m_q.size() != 0) m[m_q[0].a] = 1'b1;
    return m;
  endfunction
  task automatic model_step();
    logic acc;
    acc = wr_valid && m_ready();
    if (m_q.size() != 0 && !hold) begin
      m_regs[m_q[0].a] = m_q[0].d;
      void'(m_q.pop_front());
      m_cnt++;
    end
    if (acc) m_q.push_back('{wr_addr, wr_data});
  endtask
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic chk_model(string n);
    chk({n, " ready"}, 32'(wr_ready), 32'(m_ready()));
    chk({n, " rd_a"}, 32'(rd_a_data), 32'(m_read(rd_a_addr)));
    chk({n, " rd_b"}, 32'(rd_b_data), 32'(m_read(rd_b_addr)));
    chk({n, " mask"}, 32'(pend_mask), 32'(m_mask()));
    chk({n, " cnt"}, 32'(commit_cnt), 32'(m_cnt % 65536));
  endtask
  task automatic drive(logic v, logic [2:0] a, logic [15:0] d, logic h);
    wr_valid = v; wr_addr = a; wr_data = d; hold = h;
  endtask
  typedef struct {
    logic wv; logic [2:0] wa; logic [15:0] wd; logic h; logic [2:0] ra, rb;
    logic er; logic [15:0] ea, eb; logic [7:0] em; logic [15:0] ec;
  } vec_t;
  vec_t tbl [11];
  logic [15:0] base;
  initial begin
    tbl[0]  = '{1, 5, 16'hFEEF, 0, 5, 0, 1, 16'h0000, 16'h0000, 8'h00, 16'd0};
    tbl[1]  = '{0, 0, 16'h0000, 0, 5, 5, 1, 16'hFEEF, 16'hFEEF, 8'h20, 16'd0};
    tbl[2]  = '{0, 0, 16'h0000, 0, 5, 0, 1, 16'hFEEF, 16'h0000, 8'h00, 16'd1};
    tbl[3]  = '{1, 4, 16'h10AF, 0, 4, 7, 1, 16'h0000, 16'h0000, 8'h00, 16'd1};
    tbl[4]  = '{1, 7, 16'hAAAA, 1, 4, 7, 0, 16'h10AF, 16'h0000, 8'h10, 16'd1};
    tbl[5]  = '{1, 7, 16'hAAAA, 1, 4, 7, 0, 16'h10AF, 16'h0000, 8'h10, 16'd1};
    tbl[6]  = '{1, 7, 16'hAAAA, 1, 4, 7, 0, 16'h10AF, 16'h0000, 8'h10, 16'd1};
    tbl[7]  = '{1, 7, 16'hAAAA, 0, 4, 7, 1, 16'h10AF, 16'h0000, 8'h10, 16'd1};
    tbl[8]  = '{0, 0, 16'h0000, 0, 4, 7, 1, 16'h10AF, 16'hAAAA, 8'h80, 16'd2};
    tbl[9]  = '{0, 0, 16'h0000, 0, 4, 7, 1, 16'h10AF, 16'hAAAA, 8'h00, 16'd3};
    tbl[10] = '{0, 0, 16'h0000, 1, 3, 4, 1, 16'h0000, 16'h10AF, 8'h00, 16'd3};
    model_reset();
    #2;
    chk("reset rd_a", 32'(rd_a_data), 32'h0);
    chk("reset mask", 32'(pend_mask), 32'h0);
    chk("reset ready", 32'(wr_ready), 32'h1);
    chk("reset cnt", 32'(commit_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    foreach (tbl[i]) begin
      drive(tbl[i].wv, tbl[i].wa, tbl[i].wd, tbl[i].h);
      rd_a_addr = tbl[i].ra; rd_b_addr = tbl[i].rb;
      #1;
      chk($sformatf("vec%0d ready", i), 32'(wr_ready), 32'(tbl[i].er));
      chk($sformatf("vec%0d rd_a", i), 32'(rd_a_data), 32'(tbl[i].ea));
      chk($sformatf("vec%0d rd_b", i), 32'(rd_b_data), 32'(tbl[i].eb));
      chk($sformatf("vec%0d mask", i), 32'(pend_mask), 32'(tbl[i].em));
      chk($sformatf("vec%0d cnt", i), 32'(commit_cnt), 32'(tbl[i].ec));
      tick();
    end
    base = commit_cnt;
    for (int i = 0; i < 8; i++) begin
      drive(1, 3'(i), 16'(16'h1111 * i), 0);
      #1;
      chk($sformatf("stream%0d ready", i), 32'(wr_ready), 32'h1);
      tick();
    end
    drive(0, 0, 0, 0);
    tick();
    for (int i = 0; i < 8; i++) begin
      rd_a_addr = 3'(i);
      #1;
      chk($sformatf("stream reg%0d", i), 32'(rd_a_data), 32'(16'h1111 * i));
    end
    chk("stream cnt", 32'(commit_cnt), 32'(16'(base + 16'd8)));
    drive(1, 2, 16'h0001, 0); #1; tick();
    drive(1, 2, 16'h0002, 0); rd_a_addr = 2; #1;
    chk("rewrite fwd1", 32'(rd_a_data), 32'h0001);
    tick();
    drive(0, 0, 0, 0); #1;
    chk("rewrite fwd2", 32'(rd_a_data), 32'h0002);
    tick(); tick();
    chk("rewrite reg2", 32'(rd_a_data), 32'h0002);
    drive(1, 6, 16'hBEEF, 0); #1; tick();
    drive(0, 0, 0, 1); rd_a_addr = 6; #1;
    chk("midrst fwd", 32'(rd_a_data), 32'hBEEF);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst rd_a", 32'(rd_a_data), 32'h0);
    chk("midrst mask", 32'(pend_mask), 32'h0);
    chk("midrst ready", 32'(wr_ready), 32'h1);
    chk("midrst cnt", 32'(commit_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    hold = 1'b0;
    tick(); tick();
    chk("midrst reg6", 32'(rd_a_data), 32'h0);
    chk("midrst cnt2", 32'(commit_cnt), 32'h0);
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, 3'($urandom), 16'($urandom), ($urandom % 3) == 0);
      rd_a_addr = 3'($urandom); rd_b_addr = 3'($urandom);
      #1;
      chk_model($sformatf("rand%0d", i));
      tick();
    end
    drive(0, 0, 0, 0);
    #3;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 65536; i++) begin
      drive(1, 3'($urandom), 16'($urandom), 0);
      tick();
    end
    drive(0, 0, 0, 0);
    #1;
    chk("wrap ffff", 32'(commit_cnt), 32'hFFFF);
    tick();
    chk("wrap zero", 32'(commit_cnt), 32'h0);
    for (int i = 0; i < 8; i++) begin
      rd_a_addr = 3'(i); rd_b_addr = 3'(7 - i);
      #1;
      chk_model($sformatf("wrap reg%0d", i));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
